// File: rtl/merge_run_scheduler.sv
// Deals 0-terminated sorted runs alternately into two merger FIFOs, then closes/pads to keep runs paired.
// Zero-latency: pop and write in the same cycle; a full destination stalls the stream. Optional counters: MERGE_RUN_SCHEDULER_STATS_EN.
module merge_run_scheduler #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [DATA_WIDTH-1:0]  i_src_item,
  input  logic                   i_src_empty,
  input  logic                   i_src_done,
  output logic                   o_src_read,
  output logic [DATA_WIDTH-1:0]  o_item,
  output logic                   o_fifo_1_write,
  input  logic                   i_fifo_1_full,
  output logic                   o_fifo_2_write,
  input  logic                   i_fifo_2_full,
  output logic                   o_busy,
  output logic                   o_done,
`ifdef MERGE_RUN_SCHEDULER_STATS_EN
  output logic [COUNT_WIDTH-1:0] o_items_1,
  output logic [COUNT_WIDTH-1:0] o_items_2,
`endif
  output logic [COUNT_WIDTH-1:0] o_run_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROUTE,
    S_CLOSE,
    S_PAD,
    S_DONE
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  state_t                 finish_state;
  logic                   dest;
  logic                   open;
  logic                   dest_full;
  logic                   finish;
  logic                   wr;
  logic                   wr_dest;
  logic [COUNT_WIDTH-1:0] run_count;

  assign dest_full = dest ? i_fifo_2_full : i_fifo_1_full;
  assign finish    = i_src_empty & i_src_done;

  // An open run must be closed first; an even number of runs leaves dest=0 and needs no pad.
  always_comb begin
    finish_state = S_DONE;
    if (open)
      finish_state = S_CLOSE;
    else if (dest)
      finish_state = S_PAD;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      dest      <= 1'b0;
      open      <= 1'b0;
      run_count <= '0;
    end else begin
      state <= state_nxt;
      if (wr) begin
        // PAD always targets dest=1, so toggling there lands on dest=0 as well.
        if (o_item == '0) begin
          dest      <= ~dest;
          open      <= 1'b0;
          run_count <= run_count + COUNT_WIDTH'(1);
        end else begin
          open <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!i_src_empty)
          state_nxt = S_ROUTE;
        else if (finish)
          state_nxt = finish_state;
      end
      S_ROUTE: begin
        if (finish)
          state_nxt = finish_state;
      end
      S_CLOSE: begin
        if (wr)
          state_nxt = dest ? S_DONE : S_PAD;
      end
      S_PAD: begin
        if (wr)
          state_nxt = S_DONE;
      end
      default: state_nxt = S_DONE;
    endcase
  end

  always_comb begin
    o_src_read = 1'b0;
    wr         = 1'b0;
    wr_dest    = dest;
    o_item     = '0;
    if (!i_rst) begin
      case (state)
        S_ROUTE: begin
          if (!i_src_empty && !dest_full) begin
            o_src_read = 1'b1;
            wr         = 1'b1;
            o_item     = i_src_item;
          end
        end
        S_CLOSE: wr = !dest_full;
        S_PAD: begin
          wr_dest = 1'b1;
          wr      = !i_fifo_2_full;
        end
        default: ;
      endcase
    end
  end

  assign o_fifo_1_write = wr & ~wr_dest;
  assign o_fifo_2_write = wr & wr_dest;
  assign o_busy         = (state == S_ROUTE) || (state == S_CLOSE) || (state == S_PAD);
  assign o_done         = (state == S_DONE);
  assign o_run_count    = run_count;

`ifdef MERGE_RUN_SCHEDULER_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_items_1 <= '0;
      o_items_2 <= '0;
    end else if (wr && o_item != '0) begin
      if (wr_dest)
        o_items_2 <= o_items_2 + COUNT_WIDTH'(1);
      else
        o_items_1 <= o_items_1 + COUNT_WIDTH'(1);
    end
  end
`endif

endmodule
